// File: rtl/serial_receiver.sv
// 8N1 serial receiver with mid-bit sampling, a small receive FIFO and sticky
// overflow / framing-error flags that software clears explicitly.
module serial_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       clear_errors,
  output logic       overflow,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t             state, state_next;
  logic               rx_meta, rxs;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               push_req;
  logic               cnt_done;

  logic load_half, load_full, shift_en, push_set, ferr_set;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, push_ok, ovf_evt;

  // Synchronizer idles high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rxs) state_next = START;
      START:     if (cnt_done) state_next = rxs ? IDLE : DATA;
      DATA:      if (cnt_done && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (cnt_done) state_next = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    push_set  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:  load_half = !rxs;
      START: load_full = cnt_done && !rxs;
      DATA: begin
        shift_en  = cnt_done;
        load_full = cnt_done;
      end
      STOP: begin
        push_set = cnt_done && rxs;
        ferr_set = cnt_done && !rxs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= push_set;
      if (load_half) begin
        cnt     <= HALF_LOAD;
        bit_idx <= '0;
      end else if (load_full) begin
        cnt <= FULL_LOAD;
      end else if (!cnt_done) begin
        cnt <= cnt - 1'b1;
      end
      if (shift_en) begin
        shift   <= {rxs, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign pop      = rd_en && rd_valid;
  assign push_ok  = push_req && (!full || pop);
  assign ovf_evt  = push_req && full && !pop;

  // NOTE: storage is small, so it is reset to make an empty FIFO read 8'h00.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event in the clearing cycle wins over clear_errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      overflow    <= (overflow && !clear_errors) || ovf_evt;
      frame_error <= (frame_error && !clear_errors) || ferr_set;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frames for the corner cases
// plus random frames checked against a frame-level queue model.
module tb_serial_receiver;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // Edges after the start bit is driven: 2 sync flops + 1 detect, half a bit,
  // nine bit periods to the stop sample, then one more edge to write the FIFO.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;
  localparam int PUSH_EDGE = STOP_EDGE + 1;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, clear_errors;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, frame_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         ovf_m, ferr_m;

  serial_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .clear_errors(clear_errors),
    .overflow(overflow), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rd_valid"}, rd_valid, q.size() != 0);
    if (q.size() != 0) check({tag, ".rd_data"}, rd_data, q[0]);
    check({tag, ".overflow"}, overflow, ovf_m);
    check({tag, ".frame_error"}, frame_error, ferr_m);
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pop_valid"}, rd_valid, q.size() != 0);
    if (q.size() != 0) check({tag, ".pop_data"}, rd_data, q[0]);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    ovf_m  = 1'b0;
    ferr_m = 1'b0;
  endtask

  // Drives one frame; optionally pops in the push cycle or clears flags in the
  // stop-sample cycle, then updates the model with the frame-level outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold,
                            input bit rd_at_push, input bit clr_at_stop);
    logic [9:0] bits;
    bit         accept;
    bits = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rx           = bits[c / CPB];
      rd_en        = rd_at_push && (c == PUSH_EDGE - 1);
      clear_errors = clr_at_stop && (c == STOP_EDGE - 1);
      tick();
    end
    rd_en        = 1'b0;
    clear_errors = 1'b0;
    tick();
    if (clr_at_stop) begin
      ovf_m  = 1'b0;
      ferr_m = 1'b0;
    end
    if (rd_at_push && q.size() != 0) void'(q.pop_front());
    accept = stop_ok && (q.size() < DEPTH);
    if (!stop_ok) ferr_m = 1'b1;
    else if (accept) q.push_back(b);
    else ovf_m = 1'b1;
    if (stop_ok) check("valid_after_stop", rd_valid, 1);
    if (!stop_ok) begin
      rx = 1'b0;
      repeat (low_hold) tick();
    end
    idle(CPB);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_errors = 1'b0;
    ovf_m = 1'b0; ferr_m = 1'b0;
    repeat (3) tick();
    check("reset.rd_valid", rd_valid, 0);
    check("reset.rd_data", rd_data, 8'h00);
    check("reset.overflow", overflow, 0);
    check("reset.frame_error", frame_error, 0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 1, 0, 0, 0);
    check_state("a5");
    pop_one("a5");

    rx = 1'b0;
    repeat (3) tick();
    idle(CPB * 12);
    check_state("false_start");

    send_frame(8'h3C, 0, 20, 0, 0);
    check_state("frame_err");
    send_frame(8'h11, 1, 0, 0, 0);
    check_state("after_ferr");
    pop_one("after_ferr");
    clear_flags();
    check_state("cleared");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0, 0);
    check_state("overflow");
    for (int i = 0; i < 4; i++) pop_one("drain");
    check("drained.rd_valid", rd_valid, 0);
    clear_flags();

    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1, 0, 0, 0);
    send_frame(8'h05, 1, 0, 1, 0);
    check_state("full_push_pop");
    for (int i = 0; i < 4; i++) pop_one("full_drain");

    // Reset in the middle of data bit 3 of a frame.
    for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
      rx = (c < CPB) ? 1'b0 : 1'(c % 2);
      tick();
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0; ferr_m = 1'b0;
    idle(CPB * 12);
    check_state("mid_reset");
    send_frame(8'hFF, 1, 0, 0, 0);
    check_state("after_reset");
    pop_one("after_reset");

    send_frame(8'h3C, 0, 5, 0, 1);
    check_state("clear_vs_err");
    clear_flags();
    check_state("clear_alone");

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit         ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, $urandom_range(1, 20), 0, 0);
      check_state("rand_frame");
      repeat ($urandom_range(0, 3)) pop_one("rand_pop");
      if ($urandom_range(0, 3) == 0) clear_flags();
      check_state("rand_after");
      idle($urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit period (legal values are 4 or greater; 868 gives 115200 baud at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count (a power of two, 2 or greater).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_en, input, 1 bit: pop request for the FIFO head.
REQ-007 SHALL have port rd_data, output, 8 bits: the FIFO head byte, valid while rd_valid is high.
REQ-008 SHALL have port rd_valid, output, 1 bit: high when the FIFO is non-empty.
REQ-009 SHALL have port clear_errors, input, 1 bit: clears both sticky error flags.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, a received byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_error, output, 1 bit: sticky flag, a stop bit was sampled low.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 In IDLE, when rxs is low, the block SHALL enter START and load the bit counter with CLKS_PER_BIT/2 - 1 (integer division).
REQ-015 At the end of the START count, if rxs is high the block SHALL return to IDLE (false start, no flags set); otherwise it SHALL enter DATA.
REQ-016 In DATA, the block SHALL sample rxs every CLKS_PER_BIT cycles, shift it into the data register LSB first, and enter STOP after the 8th sample.
REQ-017 In STOP, after CLKS_PER_BIT cycles the block SHALL sample rxs.
REQ-018 If the stop sample is high, the block SHALL push the byte and go to IDLE.
REQ-019 If the stop sample is low, the block SHALL discard the byte, set frame_error, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL remain until rxs is high, then go to IDLE.
REQ-021 A push SHALL write the FIFO on the cycle after the stop sample; rd_valid SHALL be high on the following cycle.
REQ-022 rd_data SHALL reflect the head combinationally from FIFO storage.
REQ-023 rd_en with rd_valid high SHALL remove the head, taking effect at the next edge.
REQ-024 rd_en with rd_valid low SHALL be ignored.
REQ-025 A push into a full FIFO without a simultaneous pop SHALL drop the byte, leave the contents unchanged, and set overflow.
REQ-026 A push and pop in the same cycle when the FIFO is full SHALL both take effect without setting overflow.
REQ-027 A push and pop in the same cycle when the FIFO is empty SHALL ignore the pop and accept the push.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a counter of width log2(FIFO_DEPTH)+1.
REQ-029 clear_errors SHALL clear overflow and frame_error at the next edge, except that a new error event in the same cycle SHALL win and leave its flag set.

Reset
REQ-030 On reset, the block SHALL enter IDLE, set the synchronizer flops to 1, and empty the FIFO so that rd_valid=0 and rd_data=8'h00.
REQ-031 On reset, overflow and frame_error SHALL be 0, and all counters and the shift register SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no push and no flags; the next falling edge after rst deasserts SHALL start a new frame.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-033 Send 8'hA5 as an 8N1 frame: rd_valid rises within 2 cycles after the stop-bit sample, rd_data=8'hA5, and no flags are set.
REQ-034 Pull rx low for 3 cycles only, then drive it high: the block returns to IDLE, with no push and no flags.
REQ-035 Send 8'h3C with the stop bit low, then hold rx low for 20 cycles, then release it: frame_error=1, no push, and the next valid frame 8'h11 is received correctly.
REQ-036 Send 5 bytes 01..05 with no reads: the FIFO holds 01..04, overflow=1, and popping 4 times yields 01,02,03,04, after which rd_valid=0.
REQ-037 With the FIFO full, assert rd_en in exactly the push cycle: overflow stays 0, and the contents become 02,03,04,05.
REQ-038 Assert rst during the 4th data bit: no push occurs, the flags stay 0, and a following frame 8'hFF is received correctly; separately, assert clear_errors in the same cycle as a frame error and check that frame_error remains 1.
